// File: rtl/ex_stage_pipe_if.sv
// rtl/ex_stage_pipe_if.sv - upstream op and downstream result handshake bundle for the execute stage
interface ex_stage_pipe_if #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 8,
    parameter int SH_W   = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_pc;
    logic [DATA_W-1:0] in_reg1;
    logic [DATA_W-1:0] in_reg2;
    logic [IMM_W-1:0]  in_imm;
    logic              in_use_imm;
    logic              in_use_pc;
    logic [3:0]        in_alu_op;
    logic [SH_W-1:0]   in_sh_amt;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [2:0]        out_flags;

    // Master drives ops and consumes results (pipeline neighbours / bench)
    modport master (
        output in_valid, in_pc, in_reg1, in_reg2, in_imm, in_use_imm, in_use_pc,
               in_alu_op, in_sh_amt, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    // Slave is the execute stage itself
    modport slave (
        input  in_valid, in_pc, in_reg1, in_reg2, in_imm, in_use_imm, in_use_pc,
               in_alu_op, in_sh_amt, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/ex_stage_pipe.sv
// rtl/ex_stage_pipe.sv - registered execute stage with iterative multiply, sticky flags and flush
module ex_stage_pipe #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 8,
    parameter int SH_W   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    ex_stage_pipe_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int MSB   = DATA_W - 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_NOR  = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_SRA  = 4'd6;
    localparam logic [3:0] OP_MUL  = 4'd7;
    localparam logic [3:0] OP_PASS = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FULL
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [2:0]        flags_q, flags_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic                     in_ready_c;
    logic                     accept;
    logic signed [IMM_W-1:0]  imm_s;
    logic [DATA_W-1:0]        src0, src1;
    logic [DATA_W-1:0]        sum, diff;
    logic                     v_add, v_sub;
    logic [DATA_W-1:0]        alu_res;
    logic [2:0]               alu_flags;

    // Operand selection; the signed size cast sign-extends the immediate
    assign imm_s = bus.in_imm;
    assign src0  = bus.in_use_pc  ? bus.in_pc : bus.in_reg1;
    assign src1  = bus.in_use_imm ? DATA_W'(imm_s) : bus.in_reg2;

    assign sum   = src0 + src1;
    assign diff  = src0 - src1;
    assign v_add = (src0[MSB] == src1[MSB]) && (sum[MSB]  != src0[MSB]);
    assign v_sub = (src0[MSB] != src1[MSB]) && (diff[MSB] != src0[MSB]);

    // Single-cycle ALU result and the flag vector {N,Z,V} it would produce
    always_comb begin
        alu_res   = sum;
        alu_flags = {sum[MSB], (sum == '0), v_add};
        case (bus.in_alu_op)
            OP_SUB: begin
                alu_res   = diff;
                alu_flags = {diff[MSB], (diff == '0), v_sub};
            end
            OP_AND: begin
                alu_res   = src0 & src1;
                alu_flags = {flags_q[2], ((src0 & src1) == '0), flags_q[0]};
            end
            OP_NOR: begin
                alu_res   = ~(src0 | src1);
                alu_flags = {flags_q[2], ((~(src0 | src1)) == '0), flags_q[0]};
            end
            OP_SLL: begin
                alu_res   = src0 << bus.in_sh_amt;
                alu_flags = {flags_q[2], ((src0 << bus.in_sh_amt) == '0), flags_q[0]};
            end
            OP_SRL: begin
                alu_res   = src0 >> bus.in_sh_amt;
                alu_flags = {flags_q[2], ((src0 >> bus.in_sh_amt) == '0), flags_q[0]};
            end
            OP_SRA: begin
                alu_res   = DATA_W'($signed(src0) >>> bus.in_sh_amt);
                alu_flags = {flags_q[2], (alu_res == '0), flags_q[0]};
            end
            OP_PASS: begin
                alu_res   = src1;
                alu_flags = flags_q;
            end
            default: begin
                alu_res   = sum;
                alu_flags = {sum[MSB], (sum == '0), v_add};
            end
        endcase
    end

    // Next-state, handshake and datapath update; flush overrides everything
    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        flags_d    = flags_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        in_ready_c = 1'b0;
        accept     = 1'b0;

        case (state_q)
            S_IDLE:  in_ready_c = 1'b1;
            S_FULL:  in_ready_c = bus.out_ready;
            default: in_ready_c = 1'b0;
        endcase

        if (flush) begin
            in_ready_c = 1'b0;
            state_d    = S_IDLE;
            acc_d      = '0;
            cnt_d      = '0;
        end else begin
            accept = bus.in_valid && in_ready_c;
            case (state_q)
                S_BUSY: begin
                    if (cnt_q == CNT_W'(DATA_W)) begin
                        result_d = acc_q;
                        flags_d  = {acc_q[MSB], (acc_q == '0), flags_q[0]};
                        state_d  = S_FULL;
                    end else begin
                        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_q >> 1;
                        cnt_d    = cnt_q + 1'b1;
                    end
                end
                S_FULL: begin
                    if (bus.out_ready && !accept) begin
                        state_d = S_IDLE;
                    end
                end
                default: ;
            endcase

            if (accept) begin
                if (bus.in_alu_op == OP_MUL) begin
                    mcand_d  = src0;
                    mplier_d = src1;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_BUSY;
                end else begin
                    result_d = alu_res;
                    flags_d  = alu_flags;
                    state_d  = S_FULL;
                end
            end
        end
    end

    // State, output register, flags and multiplier registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            flags_q  <= 3'b000;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = (state_q == S_FULL);
    assign bus.out_result = result_q;
    assign bus.out_flags  = flags_q;
endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb/tb_ex_stage_pipe.sv - directed vector bench for ex_stage_pipe
module tb_ex_stage_pipe;
    logic clk;
    logic rst_n;
    logic flush;

    ex_stage_pipe_if #(.DATA_W(16), .IMM_W(8), .SH_W(4)) bus ();

    ex_stage_pipe #(.DATA_W(16), .IMM_W(8), .SH_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        use_pc;
        logic        use_imm;
        logic [15:0] pc;
        logic [15:0] r1;
        logic [15:0] r2;
        logic [7:0]  imm;
        logic [3:0]  op;
        logic [3:0]  sh;
        logic [15:0] exp_res;
        logic [2:0]  exp_flags;
    } vec_t;

    vec_t vecs[13];
    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic use_pc, input logic use_imm, input logic [15:0] pc,
                         input logic [15:0] r1, input logic [15:0] r2, input logic [7:0] imm,
                         input logic [3:0] op, input logic [3:0] sh);
        bus.in_valid   = 1'b1;
        bus.in_use_pc  = use_pc;
        bus.in_use_imm = use_imm;
        bus.in_pc      = pc;
        bus.in_reg1    = r1;
        bus.in_reg2    = r2;
        bus.in_imm     = imm;
        bus.in_alu_op  = op;
        bus.in_sh_amt  = sh;
    endtask

    task automatic setv(input int i, input logic use_pc, input logic use_imm, input logic [15:0] pc,
                        input logic [15:0] r1, input logic [15:0] r2, input logic [7:0] imm,
                        input logic [3:0] op, input logic [3:0] sh,
                        input logic [15:0] er, input logic [2:0] ef);
        vecs[i].use_pc = use_pc; vecs[i].use_imm = use_imm; vecs[i].pc = pc;
        vecs[i].r1 = r1; vecs[i].r2 = r2; vecs[i].imm = imm; vecs[i].op = op;
        vecs[i].sh = sh; vecs[i].exp_res = er; vecs[i].exp_flags = ef;
    endtask

    // Drive a single-cycle op at the current negedge; check right after the accepting edge
    task automatic run_single(input string name, input logic [15:0] r1, input logic [15:0] r2,
                              input logic [3:0] op, input logic [15:0] er, input logic [2:0] ef);
        drive(1'b0, 1'b0, 16'h0, r1, r2, 8'h00, op, 4'h0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk({name, "_valid"}, bus.out_valid, 1);
        chk({name, "_res"}, bus.out_result, er);
        chk({name, "_flags"}, bus.out_flags, ef);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 8'h0, 4'd0, 4'd0);
        bus.in_valid = 1'b0;

        setv(0,  0, 0, 16'h0000, 16'h7FFF, 16'h0001, 8'h00, 4'd0,  4'd0,  16'h8000, 3'b101);
        setv(1,  0, 0, 16'h0000, 16'h8004, 16'h0000, 8'h00, 4'd6,  4'd2,  16'hE001, 3'b101);
        setv(2,  0, 0, 16'h0000, 16'hF0F0, 16'h0F0F, 8'h00, 4'd2,  4'd0,  16'h0000, 3'b111);
        setv(3,  0, 1, 16'h0000, 16'h1111, 16'h2222, 8'h80, 4'd8,  4'd0,  16'hFF80, 3'b111);
        setv(4,  0, 0, 16'h0000, 16'h0005, 16'h0005, 8'h00, 4'd1,  4'd0,  16'h0000, 3'b010);
        setv(5,  1, 1, 16'h0100, 16'h5555, 16'h0000, 8'hFE, 4'd0,  4'd0,  16'h00FE, 3'b000);
        setv(6,  0, 0, 16'h0000, 16'h0000, 16'hFFFF, 8'h00, 4'd3,  4'd0,  16'h0000, 3'b010);
        setv(7,  0, 0, 16'h0000, 16'h0001, 16'h0000, 8'h00, 4'd4,  4'd15, 16'h8000, 3'b000);
        setv(8,  0, 0, 16'h0000, 16'h8000, 16'h0000, 8'h00, 4'd5,  4'd15, 16'h0001, 3'b000);
        setv(9,  0, 0, 16'h0000, 16'h1234, 16'h0000, 8'h00, 4'd4,  4'd0,  16'h1234, 3'b000);
        setv(10, 0, 0, 16'h0000, 16'h8000, 16'h0000, 8'h00, 4'd6,  4'd0,  16'h8000, 3'b000);
        setv(11, 0, 0, 16'h0000, 16'hFFFF, 16'h0001, 8'h00, 4'd12, 4'd0,  16'h0000, 3'b010);
        setv(12, 0, 0, 16'h0000, 16'h8000, 16'h0001, 8'h00, 4'd1,  4'd0,  16'h7FFF, 3'b001);

        repeat (2) @(negedge clk);
        chk("reset_valid", bus.out_valid, 0);
        chk("reset_result", bus.out_result, 0);
        chk("reset_flags", bus.out_flags, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", bus.in_ready, 1);

        // Back-to-back table vectors with the consumer always ready
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].use_pc, vecs[i].use_imm, vecs[i].pc, vecs[i].r1, vecs[i].r2,
                  vecs[i].imm, vecs[i].op, vecs[i].sh);
            chk($sformatf("vec%0d_ready", i), bus.in_ready, 1);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), bus.out_valid, 1);
            chk($sformatf("vec%0d_res", i), bus.out_result, vecs[i].exp_res);
            chk($sformatf("vec%0d_flags", i), bus.out_flags, vecs[i].exp_flags);
        end
        @(posedge clk); #1;
        chk("drain_idle", bus.out_valid, 0);

        // MUL latency: result visible 17 edges after the accepting edge; V holds
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0, 16'h0012, 16'h0034, 8'h00, 4'd7, 4'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus.out_ready = k[0];
            @(posedge clk); #1;
            if (bus.out_valid) begin lat = k; break; end
            chk($sformatf("mul_busy_ready%0d", k), bus.in_ready, 0);
        end
        chk("mul_latency", lat, 17);
        chk("mul_res", bus.out_result, 16'h03A8);
        chk("mul_flags", bus.out_flags, 3'b001);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("mul_drain", bus.out_valid, 0);

        // Flush on the fifth BUSY cycle of a MUL: no result ever appears
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0, 16'h0003, 16'h0003, 8'h00, 4'd7, 4'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1 chk("flush_busy_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy_valid", bus.out_valid, 0);
        chk("flush_busy_flags", bus.out_flags, 3'b001);
        lat = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) lat++;
        end
        chk("flush_busy_no_result", lat, 0);

        // Backpressure: held result stays put, then the next op enters with no bubble
        @(negedge clk);
        bus.out_ready = 1'b0;
        run_single("bp_first", 16'h1200, 16'h0034, 4'd0, 16'h1234, 3'b000);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0, 16'h0001, 16'h0001, 8'h00, 4'd0, 4'd0);
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_ready_low", bus.in_ready, 0);
            @(posedge clk); #1;
            chk("bp_hold_valid", bus.out_valid, 1);
            chk("bp_hold_res", bus.out_result, 16'h1234);
            chk("bp_hold_flags", bus.out_flags, 3'b000);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1 chk("bp_ready_high", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("bp_next_valid", bus.out_valid, 1);
        chk("bp_next_res", bus.out_result, 16'h0002);

        // Flush while FULL with a flag-changing op presented: op discarded
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0, 16'h0005, 16'h0005, 8'h00, 4'd1, 4'd0);
        flush = 1'b1;
        #1 chk("flush_full_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_full_valid", bus.out_valid, 0);
        chk("flush_full_flags", bus.out_flags, 3'b000);

        // Async reset in the middle of a MUL after flags were made non-zero
        @(negedge clk);
        bus.out_ready = 1'b1;
        run_single("pre_rst", 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 3'b101);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0, 16'h0002, 16'h0002, 8'h00, 4'd7, 4'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", bus.out_valid, 0);
        chk("rst_async_flags", bus.out_flags, 3'b000);
        chk("rst_async_res", bus.out_result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_single("post_rst", 16'h0003, 16'h0004, 4'd0, 16'h0007, 3'b000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
- Parametrised, registered execute stage for the pipelined core.
- Selects operands from register values, PC and a sign-extended immediate, and computes the ALU result.
- Holds the result in an output pipeline register with valid/ready handshakes on both sides.
- Adds an iterative multi-cycle multiply, a sticky N/Z/V flags register, and a synchronous flush.

Parameters:
- DATA_W, 16, datapath width (≥8)
- IMM_W, 8, immediate field width before sign extension (≤DATA_W)
- SH_W, 4, shift-amount width; must equal clog2(DATA_W)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of in-flight and held results
- in_valid  in  1  upstream presents an op
- in_ready  out  1  stage accepts op this cycle
- in_pc  in  DATA_W  PC of the instruction
- in_reg1  in  DATA_W  source register 1
- in_reg2  in  DATA_W  source register 2
- in_imm  in  IMM_W  raw immediate
- in_use_imm  in  1  src1 = sext(in_imm), else in_reg2
- in_use_pc  in  1  src0 = in_pc, else in_reg1
- in_alu_op  in  4  operation code
- in_sh_amt  in  SH_W  shift amount
- out_valid  out  1  result register holds a valid result
- out_ready  in  1  downstream takes result
- out_result  out  DATA_W  registered result
- out_flags  out  3  {N,Z,V} flags register

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; out_valid=0; out_result=0; out_flags=3'b000.
  - Multiplier accumulator and counter cleared.
- Operand selection:
  - src0 = in_use_pc ? in_pc : in_reg1.
  - src1 = in_use_imm ? {sign-extended in_imm} : in_reg2.
- Op codes:
  - 0 ADD, 1 SUB (src0−src1), 2 AND, 3 NOR.
  - 4 SLL, 5 SRL, 6 SRA: src0 shifted by in_sh_amt.
  - 7 MUL: low DATA_W bits of src0*src1, unsigned.
  - 8 PASS: src1.
  - 9–15 behave as ADD.
- Accept: an op is accepted when in_valid && in_ready.
- FSM:
  - IDLE: output register empty. in_ready=1.
    - Single-cycle op accepted → result and flags written at that edge, state FULL.
    - MUL accepted → operands latched, counter=0, state BUSY.
  - BUSY: in_ready=0. Shift-add multiply, one multiplier bit per cycle. After DATA_W cycles, result written, state FULL. Total latency is DATA_W+1 edges from accept to out_valid.
  - FULL: out_valid=1. out_result and out_flags stable while out_ready=0. in_ready=out_ready.
    - out_ready=1, no new op → IDLE.
    - out_ready=1 with a single-cycle op → new result written the same edge, stay FULL (back-to-back throughput of 1/cycle).
    - out_ready=1 with MUL → BUSY.
- out_valid = (state==FULL).
- Flags: updated only on the edge a result is written into the output register.
  - ADD/SUB: N = result MSB; Z = result==0; V = signed overflow (ADD: operand signs equal and result sign differs; SUB: operand signs differ and result sign differs from src0).
  - AND/NOR/SLL/SRL/SRA: Z only; N and V hold.
  - MUL: N and Z; V holds.
  - PASS: no flag change.
- Arithmetic wraps modulo 2^DATA_W. No saturation.
- Shifts:
  - in_sh_amt=0 returns src0.
  - SRA replicates the MSB.
- flush:
  - Has priority over all other events.
  - Next state IDLE, out_valid=0, multiply aborted.
  - Flags not updated and any op presented that cycle discarded.
  - in_ready is forced 0 during flush.
- An out_ready pulse while in IDLE or BUSY has no effect.

Test Plan:
- Reset mid-MUL (rst_n low during BUSY) → out_valid=0, out_flags=000 immediately, without waiting for clk. After release, the next accepted ADD works normally.
- ADD 0x7FFF+0x0001 (reg mode), out_ready=1 → next cycle out_result=0x8000, flags N=1,Z=0,V=1. Then SUB 0x0005−0x0005 → 0x0000, N=0,Z=1,V=0.
- Immediate/PC select:
  - in_use_pc=1, pc=0x0100, imm=8'hFE, ADD → out_result=0x00FE.
  - SRA 0x8004 by 2 → 0xE001.
- MUL 0x0012*0x0034 → out_valid exactly 17 cycles after accept, out_result=0x03A8, in_ready=0 throughout BUSY.
- Backpressure: hold out_ready=0 with result 0x1234 held, in_valid=1 → in_ready=0 and result/flags stable. Raise out_ready → next op accepted the same edge, with no bubble.
- flush during BUSY (cycle 5 of MUL) and during FULL → out_valid=0 next cycle, out_flags unchanged, no result emitted.
